cpu_bus_arbiter: RTL and testbench
==================================

// Module: cpu_bus_arbiter
// PURPOSE
//  Shares the single CPU memory bus between the instruction-fetch cache (port 0) and the data side (port 1).
//  Grants one requester at a time, holds the grant until the bus acknowledges, then forces one idle cycle.
//  Sits between the fetch/memory stages and the system bus interconnect.
// PARAMETERS
//  ROUND_ROBIN  1  1 = alternate on contention; 0 = port 0 always wins.
// PORTS
//  i_clock           in   1   system clock, rising edge.
//  i_reset           in   1   asynchronous, active-high reset.
//  i_pa_request      in   1   port 0 request, level, held until o_pa_ready.
//  i_pa_rw           in   1   port 0 direction, 1 = write.
//  i_pa_address      in   32  port 0 byte address.
//  i_pa_wdata        in   32  port 0 write data.
//  o_pa_rdata        out  32  port 0 read data, valid while o_pa_ready.
//  o_pa_ready        out  1   port 0 completion, one-cycle pulse.
//  i_pb_*/o_pb_*     -    -   port 1, identical set and meaning.
//  o_bus_request     out  1   downstream request, level.
//  o_bus_rw          out  1   downstream direction.
//  o_bus_address     out  32  downstream address.
//  o_bus_wdata       out  32  downstream write data.
//  i_bus_ready       in   1   downstream completion pulse.
//  i_bus_rdata       in   32  downstream read data.
//  o_grant           out  2   one-hot current owner (debug/perf counters); 00 = none.
// BEHAVIOUR
//  Reset (async): state IDLE, o_grant=00, last-winner=port 1 (so port 0 wins first tie); all bus outputs 0, all ready 0, all rdata 0.
//  Reset mid-transaction abandons it; o_bus_request drops immediately.
//  States: IDLE -> GRANT -> RELEASE -> IDLE.
//  IDLE: no bus outputs driven (all 0). On edge with any request, register winner into o_grant, go GRANT.
//   Only one requesting: it wins. Both: ROUND_ROBIN=1 -> port != last-winner; ROUND_ROBIN=0 -> port 0.
//  GRANT: o_bus_request=1; rw/address/wdata muxed combinationally from owner port.
//   i_bus_ready=1 -> owner o_*_ready=1 and o_*_rdata=i_bus_rdata same cycle (zero added return latency).
//   Then update last-winner and go RELEASE.
//   Non-owner ready/rdata stay 0 throughout.
//  Owner drops request before i_bus_ready: treat as abort, go RELEASE; a later i_bus_ready is ignored.
//  RELEASE: exactly one cycle, o_bus_request=0, o_grant=00; guarantees the slave sees request low between transactions.
//   Then IDLE re-arbitrates. Requests arriving in GRANT/RELEASE simply wait (held level).
//  Latency: request seen in IDLE -> o_bus_request next cycle; minimum port-to-port turnaround 3 cycles (GRANT, RELEASE, IDLE).
//  Starvation: ROUND_ROBIN=1 bounds a waiting port to one foreign transaction. ROUND_ROBIN=0 may starve port 1 (accepted).
//  Assertions (sim only):
//   - o_grant never 11.
//   - o_pa_ready and o_pb_ready never both 1.
//   - o_bus_request implies o_grant != 00.
// STRUCTURE
//  Shared package (CPU_Defines): state encodings ARB_IDLE/ARB_GRANT/ARB_RELEASE, port index constants ARB_PORT_I=0/ARB_PORT_D=1.
//  Single module. Registered state + o_grant + last-winner. Combinational output mux.
//  No sub-module (a 2:1 mux does not justify one).
// TESTING
//  1. Port 0 read alone, addr 0x100, bus ready after 3 cycles with 0xDEADBEEF:
//     o_bus_request rises 1 cycle after request, o_pa_rdata=0xDEADBEEF with o_pa_ready, request low 1 cycle after.
//  2. Both request same cycle, RR=1, 4 back-to-back pairs:
//     grant order 0,1,0,1,... with a RELEASE cycle between each.
//  3. Same as 2 with ROUND_ROBIN=0, port 0 re-requests after every ready:
//     port 1 never granted; assertions hold.
//  4. Port 1 write, addr 0x2000, wdata 0x12345678, while port 0 requests mid-transaction:
//     bus carries port 1 fields unchanged until ready, port 0 granted after RELEASE.
//  5. Owner drops request before ready, then stray i_bus_ready:
//     no o_*_ready pulse, arbiter back to IDLE in 2 cycles.
//  6. Assert i_reset during GRANT:
//     o_bus_request and o_grant go 0 without waiting for a clock edge; first grant after release goes to port 0 on a tie.

Source files
------------

// File: rtl/cpu_bus_arbiter_pkg.sv
// Shared definitions for the CPU bus arbiter: state encodings, port indices,
// the per-port command bundle and the tie-break helper.
package cpu_bus_arbiter_pkg;

   localparam logic [1:0] ARB_IDLE    = 2'd0;
   localparam logic [1:0] ARB_GRANT   = 2'd1;
   localparam logic [1:0] ARB_RELEASE = 2'd2;

   localparam logic ARB_PORT_I = 1'b0;
   localparam logic ARB_PORT_D = 1'b1;

   typedef struct packed {
      logic        rw;
      logic [31:0] address;
      logic [31:0] wdata;
   } bus_cmd_t;

   function automatic logic [1:0] port_onehot(input logic port);
      return (port == ARB_PORT_D) ? 2'b10 : 2'b01;
   endfunction

   // On a tie, round-robin hands the bus to whichever port did not win last.
   function automatic logic pick_winner(input logic req_i,
                                        input logic req_d,
                                        input logic last_winner,
                                        input logic round_robin);
      logic winner;
      if (req_i && req_d) begin
         winner = round_robin ? ~last_winner : ARB_PORT_I;
      end else if (req_d) begin
         winner = ARB_PORT_D;
      end else begin
         winner = ARB_PORT_I;
      end
      return winner;
   endfunction

endpackage

// File: rtl/cpu_bus_arbiter.sv
// Two-port arbiter sharing the CPU memory bus between instruction fetch (port 0)
// and the data side (port 1); one owner at a time, one forced idle cycle after each.
module cpu_bus_arbiter
   import cpu_bus_arbiter_pkg::*;
#(
   parameter bit ROUND_ROBIN = 1'b1
) (
   input  logic        i_clock,
   input  logic        i_reset,

   input  logic        i_pa_request,
   input  logic        i_pa_rw,
   input  logic [31:0] i_pa_address,
   input  logic [31:0] i_pa_wdata,
   output logic [31:0] o_pa_rdata,
   output logic        o_pa_ready,

   input  logic        i_pb_request,
   input  logic        i_pb_rw,
   input  logic [31:0] i_pb_address,
   input  logic [31:0] i_pb_wdata,
   output logic [31:0] o_pb_rdata,
   output logic        o_pb_ready,

   output logic        o_bus_request,
   output logic        o_bus_rw,
   output logic [31:0] o_bus_address,
   output logic [31:0] o_bus_wdata,
   input  logic        i_bus_ready,
   input  logic [31:0] i_bus_rdata,

   output logic [1:0]  o_grant
);

   logic [1:0] state;
   logic       last_winner;
   logic       owner;
   logic       owner_request;
   logic       in_grant;
   logic       complete;
   logic       abort;
   logic       winner;
   bus_cmd_t   cmd_i;
   bus_cmd_t   cmd_d;
   bus_cmd_t   owner_cmd;

   assign owner         = o_grant[1];
   assign in_grant      = (state == ARB_GRANT);
   assign owner_request = (owner == ARB_PORT_D) ? i_pb_request : i_pa_request;
   assign complete      = in_grant && owner_request && i_bus_ready;
   assign abort         = in_grant && !owner_request;
   assign winner        = pick_winner(i_pa_request, i_pb_request, last_winner, ROUND_ROBIN);

   assign cmd_i     = '{rw: i_pa_rw, address: i_pa_address, wdata: i_pa_wdata};
   assign cmd_d     = '{rw: i_pb_rw, address: i_pb_address, wdata: i_pb_wdata};
   assign owner_cmd = (owner == ARB_PORT_D) ? cmd_d : cmd_i;

   // An owner that lets go of its request early abandons the transfer; it still
   // passes through RELEASE so the slave sees request low before the next owner.
   always_ff @(posedge i_clock or posedge i_reset) begin
      if (i_reset) begin
         state       <= ARB_IDLE;
         o_grant     <= 2'b00;
         last_winner <= ARB_PORT_D;
      end else begin
         case (state)
            ARB_IDLE: begin
               if (i_pa_request || i_pb_request) begin
                  o_grant <= port_onehot(winner);
                  state   <= ARB_GRANT;
               end
            end
            ARB_GRANT: begin
               if (complete) begin
                  last_winner <= owner;
                  o_grant     <= 2'b00;
                  state       <= ARB_RELEASE;
               end else if (abort) begin
                  o_grant <= 2'b00;
                  state   <= ARB_RELEASE;
               end
            end
            ARB_RELEASE: begin
               state <= ARB_IDLE;
            end
            default: begin
               o_grant <= 2'b00;
               state   <= ARB_IDLE;
            end
         endcase
      end
   end

   // Bus fields and the completion return are purely combinational off the owner.
   always_comb begin
      o_bus_request = 1'b0;
      o_bus_rw      = 1'b0;
      o_bus_address = 32'd0;
      o_bus_wdata   = 32'd0;
      o_pa_ready    = 1'b0;
      o_pa_rdata    = 32'd0;
      o_pb_ready    = 1'b0;
      o_pb_rdata    = 32'd0;
      if (in_grant) begin
         o_bus_request = 1'b1;
         o_bus_rw      = owner_cmd.rw;
         o_bus_address = owner_cmd.address;
         o_bus_wdata   = owner_cmd.wdata;
      end
      if (complete) begin
         if (owner == ARB_PORT_D) begin
            o_pb_ready = 1'b1;
            o_pb_rdata = i_bus_rdata;
         end else begin
            o_pa_ready = 1'b1;
            o_pa_rdata = i_bus_rdata;
         end
      end
   end

   a_grant_not_both : assert property (@(posedge i_clock) disable iff (i_reset)
      o_grant != 2'b11);

   a_ready_exclusive : assert property (@(posedge i_clock) disable iff (i_reset)
      !(o_pa_ready && o_pb_ready));

   a_request_has_owner : assert property (@(posedge i_clock) disable iff (i_reset)
      o_bus_request |-> (o_grant != 2'b00));

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Self-checking bench for cpu_bus_arbiter: directed scenarios on both arbitration
// policies plus randomized traffic against a transaction-level reference model.
module tb_cpu_bus_arbiter;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        pa_request, pa_rw, pb_request, pb_rw, bus_ready;
   logic [31:0] pa_address, pa_wdata, pb_address, pb_wdata, bus_rdata;

   logic [31:0] rr_pa_rdata, rr_pb_rdata, rr_bus_address, rr_bus_wdata;
   logic        rr_pa_ready, rr_pb_ready, rr_bus_request, rr_bus_rw;
   logic [1:0]  rr_grant;
   logic [31:0] fp_pa_rdata, fp_pb_rdata, fp_bus_address, fp_bus_wdata;
   logic        fp_pa_ready, fp_pb_ready, fp_bus_request, fp_bus_rw;
   logic [1:0]  fp_grant;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clock = ~clock;

   cpu_bus_arbiter #(.ROUND_ROBIN(1'b1)) dut_rr (
      .i_clock(clock), .i_reset(reset),
      .i_pa_request(pa_request), .i_pa_rw(pa_rw), .i_pa_address(pa_address),
      .i_pa_wdata(pa_wdata), .o_pa_rdata(rr_pa_rdata), .o_pa_ready(rr_pa_ready),
      .i_pb_request(pb_request), .i_pb_rw(pb_rw), .i_pb_address(pb_address),
      .i_pb_wdata(pb_wdata), .o_pb_rdata(rr_pb_rdata), .o_pb_ready(rr_pb_ready),
      .o_bus_request(rr_bus_request), .o_bus_rw(rr_bus_rw), .o_bus_address(rr_bus_address),
      .o_bus_wdata(rr_bus_wdata), .i_bus_ready(bus_ready), .i_bus_rdata(bus_rdata),
      .o_grant(rr_grant)
   );

   cpu_bus_arbiter #(.ROUND_ROBIN(1'b0)) dut_fp (
      .i_clock(clock), .i_reset(reset),
      .i_pa_request(pa_request), .i_pa_rw(pa_rw), .i_pa_address(pa_address),
      .i_pa_wdata(pa_wdata), .o_pa_rdata(fp_pa_rdata), .o_pa_ready(fp_pa_ready),
      .i_pb_request(pb_request), .i_pb_rw(pb_rw), .i_pb_address(pb_address),
      .i_pb_wdata(pb_wdata), .o_pb_rdata(fp_pb_rdata), .o_pb_ready(fp_pb_ready),
      .o_bus_request(fp_bus_request), .o_bus_rw(fp_bus_rw), .o_bus_address(fp_bus_address),
      .o_bus_wdata(fp_bus_wdata), .i_bus_ready(bus_ready), .i_bus_rdata(bus_rdata),
      .o_grant(fp_grant)
   );

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs;
      pa_request = 1'b0; pa_rw = 1'b0; pa_address = 32'd0; pa_wdata = 32'd0;
      pb_request = 1'b0; pb_rw = 1'b0; pb_address = 32'd0; pb_wdata = 32'd0;
      bus_ready  = 1'b0; bus_rdata = 32'd0;
   endtask

   task automatic apply_reset;
      idle_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_reset;
      idle_inputs();
      reset      = 1'b1;
      pa_request = 1'b1;
      pb_request = 1'b1;
      bus_ready  = 1'b1;
      bus_rdata  = 32'hFFFF_FFFF;
      for (int i = 0; i < 2; i++) begin
         tick();
         #1;
         vectors++; if (rr_grant !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_grant: got %b expected 00", rr_grant); end
         vectors++; if (rr_bus_request !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_bus_request: got %b expected 0", rr_bus_request); end
         vectors++; if (rr_bus_address !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_bus_address: got %h expected 0", rr_bus_address); end
         vectors++; if ({rr_pa_ready, rr_pb_ready} !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_ready: got %b expected 00", {rr_pa_ready, rr_pb_ready}); end
         vectors++; if (rr_pa_rdata !== 32'd0) begin miscompares++; $display("[TB] FAIL reset_rdata: got %h expected 0", rr_pa_rdata); end
         vectors++; if (fp_grant !== 2'b00) begin miscompares++; $display("[TB] FAIL reset_fp_grant: got %b expected 00", fp_grant); end
      end
      idle_inputs();
      tick();
      reset = 1'b0;
   endtask

   task automatic test_single_read;
      apply_reset();
      pa_request = 1'b1; pa_rw = 1'b0; pa_address = 32'h100;
      #1;
      vectors++; if (rr_bus_request !== 1'b0) begin miscompares++; $display("[TB] FAIL read_req_early: got %b expected 0", rr_bus_request); end
      tick(); #1;
      vectors++; if (rr_bus_request !== 1'b1) begin miscompares++; $display("[TB] FAIL read_req_rise: got %b expected 1", rr_bus_request); end
      vectors++; if (rr_grant !== 2'b01) begin miscompares++; $display("[TB] FAIL read_grant: got %b expected 01", rr_grant); end
      vectors++; if (rr_bus_address !== 32'h100) begin miscompares++; $display("[TB] FAIL read_address: got %h expected 100", rr_bus_address); end
      vectors++; if (rr_bus_rw !== 1'b0) begin miscompares++; $display("[TB] FAIL read_rw: got %b expected 0", rr_bus_rw); end
      tick(); #1;
      vectors++; if (rr_pa_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL read_ready_early: got %b expected 0", rr_pa_ready); end
      tick();
      bus_ready = 1'b1; bus_rdata = 32'hDEAD_BEEF;
      #1;
      vectors++; if (rr_pa_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL read_ready: got %b expected 1", rr_pa_ready); end
      vectors++; if (rr_pa_rdata !== 32'hDEAD_BEEF) begin miscompares++; $display("[TB] FAIL read_rdata: got %h expected deadbeef", rr_pa_rdata); end
      vectors++; if ({rr_pb_ready, rr_pb_rdata} !== 33'd0) begin miscompares++; $display("[TB] FAIL read_other_port: got %b/%h expected 0/0", rr_pb_ready, rr_pb_rdata); end
      tick();
      pa_request = 1'b0; bus_ready = 1'b0;
      #1;
      vectors++; if (rr_bus_request !== 1'b0) begin miscompares++; $display("[TB] FAIL read_req_fall: got %b expected 0", rr_bus_request); end
      vectors++; if (rr_grant !== 2'b00) begin miscompares++; $display("[TB] FAIL read_release_grant: got %b expected 00", rr_grant); end
   endtask

   // Both ports request continuously and the slave answers instantly, so every
   // third cycle is a grant; round-robin alternates, fixed priority never serves port 1.
   task automatic test_back_to_back;
      bit          is_grant;
      int          k;
      logic [1:0]  exp_rr;
      logic [1:0]  exp_fp;
      logic [31:0] exp_addr;
      apply_reset();
      pa_request = 1'b1; pa_address = 32'hA0;
      pb_request = 1'b1; pb_address = 32'hB0;
      bus_ready  = 1'b1;
      for (int c = 0; c < 30; c++) begin
         bus_rdata = 32'h5A5A_0000 + c;
         #1;
         is_grant = ((c % 3) == 1);
         k        = c / 3;
         exp_rr   = is_grant ? (((k % 2) == 1) ? 2'b10 : 2'b01) : 2'b00;
         exp_fp   = is_grant ? 2'b01 : 2'b00;
         exp_addr = is_grant ? (((k % 2) == 1) ? 32'hB0 : 32'hA0) : 32'd0;
         vectors++; if (rr_grant !== exp_rr) begin miscompares++; $display("[TB] FAIL b2b_rr_grant c=%0d: got %b expected %b", c, rr_grant, exp_rr); end
         vectors++; if (rr_bus_request !== is_grant) begin miscompares++; $display("[TB] FAIL b2b_rr_request c=%0d: got %b expected %b", c, rr_bus_request, is_grant); end
         vectors++; if (rr_bus_address !== exp_addr) begin miscompares++; $display("[TB] FAIL b2b_rr_address c=%0d: got %h expected %h", c, rr_bus_address, exp_addr); end
         vectors++; if (rr_pa_ready !== (is_grant && exp_rr == 2'b01)) begin miscompares++; $display("[TB] FAIL b2b_rr_pa_ready c=%0d: got %b", c, rr_pa_ready); end
         vectors++; if (rr_pb_ready !== (is_grant && exp_rr == 2'b10)) begin miscompares++; $display("[TB] FAIL b2b_rr_pb_ready c=%0d: got %b", c, rr_pb_ready); end
         vectors++; if (fp_grant !== exp_fp) begin miscompares++; $display("[TB] FAIL b2b_fp_grant c=%0d: got %b expected %b", c, fp_grant, exp_fp); end
         vectors++; if (fp_pa_ready !== is_grant) begin miscompares++; $display("[TB] FAIL b2b_fp_pa_ready c=%0d: got %b expected %b", c, fp_pa_ready, is_grant); end
         vectors++; if (fp_pb_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL b2b_fp_pb_ready c=%0d: got %b expected 0", c, fp_pb_ready); end
         tick();
      end
      idle_inputs();
   endtask

   task automatic test_port1_write;
      apply_reset();
      pb_request = 1'b1; pb_rw = 1'b1; pb_address = 32'h2000; pb_wdata = 32'h1234_5678;
      tick();
      pa_request = 1'b1; pa_rw = 1'b0; pa_address = 32'h300; pa_wdata = 32'hCAFE_0000;
      for (int i = 0; i < 3; i++) begin
         #1;
         vectors++; if (rr_grant !== 2'b10) begin miscompares++; $display("[TB] FAIL write_grant i=%0d: got %b expected 10", i, rr_grant); end
         vectors++; if ({rr_bus_rw, rr_bus_address, rr_bus_wdata} !== {1'b1, 32'h2000, 32'h1234_5678}) begin
            miscompares++; $display("[TB] FAIL write_fields i=%0d: got %b/%h/%h expected 1/2000/12345678", i, rr_bus_rw, rr_bus_address, rr_bus_wdata); end
         vectors++; if (rr_pa_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL write_pa_idle i=%0d: got %b expected 0", i, rr_pa_ready); end
         tick();
      end
      bus_ready = 1'b1; bus_rdata = 32'h0BAD_F00D;
      #1;
      vectors++; if ({rr_pb_ready, rr_pa_ready} !== 2'b10) begin miscompares++; $display("[TB] FAIL write_ready: got %b expected 10", {rr_pb_ready, rr_pa_ready}); end
      tick();
      pb_request = 1'b0; bus_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         #1;
         vectors++; if ({rr_bus_request, rr_grant} !== 3'b000) begin miscompares++; $display("[TB] FAIL write_gap i=%0d: got %b expected 000", i, {rr_bus_request, rr_grant}); end
         tick();
      end
      #1;
      vectors++; if (rr_grant !== 2'b01) begin miscompares++; $display("[TB] FAIL write_next_grant: got %b expected 01", rr_grant); end
      vectors++; if (rr_bus_address !== 32'h300) begin miscompares++; $display("[TB] FAIL write_next_address: got %h expected 300", rr_bus_address); end
      idle_inputs();
   endtask

   task automatic test_abort;
      apply_reset();
      pa_request = 1'b1; pa_address = 32'h440;
      tick(); #1;
      vectors++; if (rr_grant !== 2'b01) begin miscompares++; $display("[TB] FAIL abort_grant: got %b expected 01", rr_grant); end
      tick();
      pa_request = 1'b0;
      #1;
      vectors++; if (rr_pa_ready !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_drop_ready: got %b expected 0", rr_pa_ready); end
      tick();
      bus_ready = 1'b1; bus_rdata = 32'h1111_2222;
      #1;
      vectors++; if ({rr_pa_ready, rr_pb_ready} !== 2'b00) begin miscompares++; $display("[TB] FAIL abort_stray_ready: got %b expected 00", {rr_pa_ready, rr_pb_ready}); end
      vectors++; if (rr_pa_rdata !== 32'd0) begin miscompares++; $display("[TB] FAIL abort_stray_rdata: got %h expected 0", rr_pa_rdata); end
      vectors++; if (rr_bus_request !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_release: got %b expected 0", rr_bus_request); end
      tick();
      bus_ready = 1'b0; pb_request = 1'b1; pb_address = 32'h880;
      #1;
      vectors++; if (rr_bus_request !== 1'b0) begin miscompares++; $display("[TB] FAIL abort_idle: got %b expected 0", rr_bus_request); end
      tick(); #1;
      vectors++; if (rr_grant !== 2'b10) begin miscompares++; $display("[TB] FAIL abort_regrant: got %b expected 10", rr_grant); end
      vectors++; if (rr_bus_address !== 32'h880) begin miscompares++; $display("[TB] FAIL abort_regrant_addr: got %h expected 880", rr_bus_address); end
      idle_inputs();
   endtask

   task automatic test_reset_mid_grant;
      apply_reset();
      pa_request = 1'b1; pa_address = 32'h10;
      tick();
      bus_ready = 1'b1; bus_rdata = 32'h1;
      #1;
      vectors++; if (rr_pa_ready !== 1'b1) begin miscompares++; $display("[TB] FAIL rmid_first_done: got %b expected 1", rr_pa_ready); end
      tick();
      pa_request = 1'b0; bus_ready = 1'b0; pb_request = 1'b1; pb_address = 32'h20;
      tick();
      tick(); #1;
      vectors++; if (rr_grant !== 2'b10) begin miscompares++; $display("[TB] FAIL rmid_pb_grant: got %b expected 10", rr_grant); end
      reset = 1'b1;
      #1;
      vectors++; if (rr_bus_request !== 1'b0) begin miscompares++; $display("[TB] FAIL rmid_async_request: got %b expected 0", rr_bus_request); end
      vectors++; if (rr_grant !== 2'b00) begin miscompares++; $display("[TB] FAIL rmid_async_grant: got %b expected 00", rr_grant); end
      vectors++; if (rr_bus_address !== 32'd0) begin miscompares++; $display("[TB] FAIL rmid_async_address: got %h expected 0", rr_bus_address); end
      tick();
      reset = 1'b0; pa_request = 1'b1;
      tick(); #1;
      vectors++; if (rr_grant !== 2'b01) begin miscompares++; $display("[TB] FAIL rmid_tie_after_reset: got %b expected 01", rr_grant); end
      idle_inputs();
   endtask

   // Reference model: the bus is either owned or free; a finished or abandoned
   // transfer blocks arbitration for one cycle, then the first cycle with a
   // request picks the owner, which is driven on the bus from the next cycle.
   task automatic test_random_traffic(input int cycles);
      logic [1:0]  req, rw, done;
      logic [31:0] addr [2];
      logic [31:0] wdata [2];
      bit          busy;
      bit          fire;
      int          owner, last, next_arb, cnt, target;
      logic [1:0]  exp_grant;
      apply_reset();
      req = '0; rw = '0; done = '0;
      addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
      busy = 1'b0; owner = 0; last = 1; next_arb = 0; cnt = 0; target = 0;
      for (int t = 0; t < cycles; t++) begin
         if (t > 0) tick();
         for (int p = 0; p < 2; p++) begin
            if (done[p]) req[p] = 1'b0;
            if (!req[p] && ($urandom_range(0, 3) == 0)) begin
               req[p] = 1'b1; rw[p] = 1'($urandom_range(0, 1)); addr[p] = $urandom; wdata[p] = $urandom;
            end
            done[p] = 1'b0;
         end
         bus_ready = 1'b0;
         if (busy) begin
            if (cnt >= target) bus_ready = 1'b1;
            else cnt++;
         end else begin
            bus_ready = ($urandom_range(0, 7) == 0);
         end
         bus_rdata  = $urandom;
         pa_request = req[0]; pa_rw = rw[0]; pa_address = addr[0]; pa_wdata = wdata[0];
         pb_request = req[1]; pb_rw = rw[1]; pb_address = addr[1]; pb_wdata = wdata[1];
         #1;
         fire      = busy && req[owner] && bus_ready;
         exp_grant = busy ? ((owner == 1) ? 2'b10 : 2'b01) : 2'b00;
         vectors++; if (rr_bus_request !== busy) begin miscompares++; $display("[TB] FAIL rand_request t=%0d: got %b expected %b", t, rr_bus_request, busy); end
         vectors++; if (rr_grant !== exp_grant) begin miscompares++; $display("[TB] FAIL rand_grant t=%0d: got %b expected %b", t, rr_grant, exp_grant); end
         vectors++; if (rr_bus_address !== (busy ? addr[owner] : 32'd0)) begin miscompares++; $display("[TB] FAIL rand_address t=%0d: got %h expected %h", t, rr_bus_address, busy ? addr[owner] : 32'd0); end
         vectors++; if (rr_bus_wdata !== (busy ? wdata[owner] : 32'd0)) begin miscompares++; $display("[TB] FAIL rand_wdata t=%0d: got %h expected %h", t, rr_bus_wdata, busy ? wdata[owner] : 32'd0); end
         vectors++; if (rr_bus_rw !== (busy ? rw[owner] : 1'b0)) begin miscompares++; $display("[TB] FAIL rand_rw t=%0d: got %b expected %b", t, rr_bus_rw, busy ? rw[owner] : 1'b0); end
         vectors++; if (rr_pa_ready !== (fire && owner == 0)) begin miscompares++; $display("[TB] FAIL rand_pa_ready t=%0d: got %b expected %b", t, rr_pa_ready, fire && owner == 0); end
         vectors++; if (rr_pb_ready !== (fire && owner == 1)) begin miscompares++; $display("[TB] FAIL rand_pb_ready t=%0d: got %b expected %b", t, rr_pb_ready, fire && owner == 1); end
         vectors++; if (rr_pa_rdata !== ((fire && owner == 0) ? bus_rdata : 32'd0)) begin miscompares++; $display("[TB] FAIL rand_pa_rdata t=%0d: got %h", t, rr_pa_rdata); end
         vectors++; if (rr_pb_rdata !== ((fire && owner == 1) ? bus_rdata : 32'd0)) begin miscompares++; $display("[TB] FAIL rand_pb_rdata t=%0d: got %h", t, rr_pb_rdata); end
         if (busy) begin
            if (fire) begin
               done[owner] = 1'b1; last = owner; busy = 1'b0; next_arb = t + 2;
            end else if (!req[owner]) begin
               busy = 1'b0; next_arb = t + 2;
            end
         end else if (t >= next_arb && (req[0] || req[1])) begin
            if (req[0] && req[1]) owner = 1 - last;
            else owner = req[1] ? 1 : 0;
            busy = 1'b1; cnt = 0; target = $urandom_range(0, 3);
         end
      end
      tick();
      idle_inputs();
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      idle_inputs();
      test_reset();
      test_single_read();
      test_back_to_back();
      test_port1_write();
      test_abort();
      test_reset_mid_grant();
      test_random_traffic(800);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
